control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_if.sv | 49 ++++
 rtl/control_fsm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/control_fsm_if.sv
// Control bundle between the instruction-sequencing FSM and the datapath/memory.
// master = FSM side (drives strobes), slave = datapath side (drives status/instruction).
interface control_fsm_if #(
    parameter int REG_W = 1,
    parameter int OFF_W = 4
);
    localparam int INSTR_W = 3 + REG_W + OFF_W;

    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               zf;
    logic               mem_ready;

    logic [2:0]         state;
    logic               pc_we;
    logic               pc_sel;
    logic [REG_W-1:0]   pc_jmp_sel;
    logic [OFF_W-1:0]   pc_offset;
    logic               mem_req;
    logic               mem_we;
    logic               addr_sel;
    logic [OFF_W-1:0]   addr_offset;
    logic [2:0]         alu_opcode;
    logic [REG_W-1:0]   alu_sel_a;
    logic [REG_W-1:0]   alu_sel_b;
    logic               alu_we;
    logic               zf_we;
    logic               ir_we;
    logic               rf_we;
    logic [REG_W-1:0]   rf_sel;
    logic               rf_src_mem;
    logic               halt;

    modport master (
        input  start, instr, zf, mem_ready,
        output state, pc_we, pc_sel, pc_jmp_sel, pc_offset,
               mem_req, mem_we, addr_sel, addr_offset,
               alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we,
               ir_we, rf_we, rf_sel, rf_src_mem, halt
    );

    modport slave (
        output start, instr, zf, mem_ready,
        input  state, pc_we, pc_sel, pc_jmp_sel, pc_offset,
               mem_req, mem_we, addr_sel, addr_offset,
               alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we,
               ir_we, rf_we, rf_sel, rf_src_mem, halt
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing, outputs purely combinational.
// Latency FETCH-to-FETCH: ALU 4, LOAD 4, STORE 3, JUMP/JUMPZ 3 cycles without memory wait states.
// Backpressure: with CONTROL_FSM_WAITSTATE_EN, FETCH/MEMORY hold (write strobes low) until mem_ready; else mem_ready ignored.
module control_fsm #(
    parameter int REG_W = 1,
    parameter int OFF_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    control_fsm_if.master bus
);
    localparam int INSTR_W = 3 + REG_W + OFF_W;

    localparam logic [2:0] S_FETCH     = 3'b000;
    localparam logic [2:0] S_DECODE    = 3'b001;
    localparam logic [2:0] S_EXECUTE   = 3'b010;
    localparam logic [2:0] S_MEMORY    = 3'b011;
    localparam logic [2:0] S_WRITEBACK = 3'b100;
    localparam logic [2:0] S_HALT      = 3'b101;
    localparam logic [2:0] S_IDLE      = 3'b110;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;
    localparam logic [2:0] OP_JUMPZ = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    generate
        if (OFF_W < 2 * REG_W) begin : g_param_check
            $error("control_fsm: OFF_W must be >= 2*REG_W");
        end
    endgenerate

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             accept;
    logic [2:0]       opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [OFF_W-1:0] off;

    assign opcode = bus.instr[INSTR_W-1 -: 3];
    assign rd     = bus.instr[OFF_W +: REG_W];
    assign rs1    = bus.instr[OFF_W-1 -: REG_W];
    assign rs2    = bus.instr[OFF_W-REG_W-1 -: REG_W];
    assign off    = bus.instr[OFF_W-1:0];

`ifdef CONTROL_FSM_WAITSTATE_EN
    assign accept = bus.mem_ready;
`else
    // Single-cycle memory: every FETCH/MEMORY cycle completes.
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign accept = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.pc_we       = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.pc_jmp_sel  = '0;
        bus.pc_offset   = '0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.addr_sel    = 1'b0;
        bus.addr_offset = '0;
        bus.alu_opcode  = '0;
        bus.alu_sel_a   = '0;
        bus.alu_sel_b   = '0;
        bus.alu_we      = 1'b0;
        bus.zf_we       = 1'b0;
        bus.ir_we       = 1'b0;
        bus.rf_we       = 1'b0;
        bus.rf_sel      = '0;
        bus.rf_src_mem  = 1'b0;
        bus.halt        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (accept) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMORY;
                    OP_HALT:           state_d = S_HALT;
                    default:           state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: begin
                        bus.alu_opcode = opcode;
                        bus.alu_sel_a  = rs1;
                        bus.alu_sel_b  = (opcode == OP_NOT) ? '0 : rs2;
                        bus.alu_we     = 1'b1;
                        bus.zf_we      = 1'b1;
                        state_d        = S_WRITEBACK;
                    end
                    OP_JUMP, OP_JUMPZ: begin
                        // JUMPZ not taken leaves every PC output at zero.
                        if (opcode == OP_JUMP || bus.zf) begin
                            bus.pc_we      = 1'b1;
                            bus.pc_sel     = 1'b1;
                            bus.pc_jmp_sel = rd;
                            bus.pc_offset  = off;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEMORY: begin
                bus.mem_req     = 1'b1;
                bus.addr_sel    = 1'b1;
                bus.addr_offset = off;
                bus.alu_sel_a   = rd;
                if (opcode == OP_STORE) begin
                    bus.mem_we = accept;
                    if (accept) state_d = S_FETCH;
                end else if (accept) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                bus.rf_we      = 1'b1;
                bus.rf_sel     = rd;
                bus.rf_src_mem = (opcode == OP_LOAD);
                state_d        = S_FETCH;
            end
            S_HALT: begin
                bus.halt = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state = state_q;
endmodule
